// File: rtl/daq_rate_ctrl_pkg.sv
// Shared encodings for the DAQ optical link rate-change sequencer.
package daq_rate_ctrl_pkg;

  // Encodings are visible through the status register, so values are fixed.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StDrain   = 3'd1,
    StSwitch  = 3'd2,
    StRecover = 3'd3,
    StSettle  = 3'd4,
    StError   = 3'd5
  } seq_state_e;

  localparam logic RATE_1G25 = 1'b0;
  localparam logic RATE_3G2  = 1'b1;

  localparam int unsigned CntW = 16;

  // Status line of the rate-select FSM that corresponds to the commanded target.
  function automatic logic target_status(logic target, logic rate_1_25, logic rate_3_2);
    return (target == RATE_3G2) ? rate_3_2 : rate_1_25;
  endfunction

endpackage

// File: rtl/daq_tmo_cnt.sv
// Shared state-duration counter with clear, enable and an expire flag that
// fires on the last cycle of a limit-cycle interval.
module daq_tmo_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] limit_i,
  output logic             expire_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count: clear wins, saturate instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + One;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter holds 0 on the entry cycle, so limit-1 marks the limit-th cycle.
  assign expire_o = en_i && (cnt_q == (limit_i - One));

endmodule

// File: rtl/daq_rate_seq_ctrl.sv
// Rate-change sequencer: drains the framer, commands the new link rate, waits
// for the rate-select FSM to confirm, recovers on timeout and settles.
module daq_rate_seq_ctrl
  import daq_rate_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_TMO   = 1024,
  parameter int unsigned SWITCH_TMO  = 4096,
  parameter int unsigned SETTLE_CYC  = 64,
  parameter int unsigned FSM_RST_CYC = 8,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_RATE,
  input  logic       FRAME_ACTIVE,
  input  logic       RATE_1_25,
  input  logic       RATE_3_2,
  input  logic       CLR_ERR,
  output logic       DAQ_RATE,
  output logic       RATE_FSM_RST,
  output logic       HOLD_DATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic       DRAIN_FORCED,
  output logic [1:0] RETRY_CNT,
  output logic [2:0] SEQ_STATE
);

  localparam logic [1:0] MaxRetry = 2'(MAX_RETRY);

  seq_state_e state_q, state_d;
  logic       target_q, target_d;
  logic [1:0] retry_q, retry_d;
  logic       drain_forced_q, drain_forced_d;
  logic       daq_rate_q, daq_rate_d;
  logic       fsm_rst_q, fsm_rst_d;
  logic       hold_q, hold_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [CntW-1:0] limit;
  logic            cnt_en;
  logic            expire;
  logic            tgt_ok;

  assign tgt_ok = target_status(target_q, RATE_1_25, RATE_3_2);

  // Interval length for whichever state is currently being timed.
  always_comb begin
    limit  = '0;
    cnt_en = 1'b1;
    unique case (state_q)
      StDrain:   limit = CntW'(DRAIN_TMO);
      StSwitch:  limit = CntW'(SWITCH_TMO);
      StRecover: limit = CntW'(FSM_RST_CYC);
      StSettle:  limit = CntW'(SETTLE_CYC);
      default:   cnt_en = 1'b0;
    endcase
  end

  daq_tmo_cnt #(
    .Width (CntW)
  ) u_tmo_cnt (
    .clk_i    (CLK),
    .rst_i    (RST),
    .clr_i    (state_d != state_q),
    .en_i     (cnt_en),
    .limit_i  (limit),
    .expire_o (expire)
  );

  // Sequencing decisions; status beats timeout wherever both are seen.
  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    retry_d        = retry_q;
    drain_forced_d = drain_forced_q;
    unique case (state_q)
      StIdle: begin
        if (REQ_RATE != daq_rate_q) begin
          state_d        = StDrain;
          target_d       = REQ_RATE;
          retry_d        = '0;
          drain_forced_d = 1'b0;
        end
      end
      StDrain: begin
        if (!FRAME_ACTIVE) begin
          state_d = StSwitch;
        end else if (expire) begin
          state_d        = StSwitch;
          drain_forced_d = 1'b1;
        end
      end
      StSwitch: begin
        if (tgt_ok) begin
          state_d = StSettle;
        end else if (expire) begin
          if (retry_q < MaxRetry) begin
            state_d = StRecover;
            retry_d = retry_q + 2'd1;
          end else begin
            state_d = StError;
          end
        end
      end
      StRecover: begin
        if (expire) state_d = StSwitch;
      end
      StSettle: begin
        if (!tgt_ok) begin
          state_d = StSwitch;
        end else if (expire) begin
          state_d = StIdle;
        end
      end
      StError: begin
        if (CLR_ERR) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    daq_rate_d = daq_rate_q;
    fsm_rst_d  = 1'b0;
    hold_d     = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_d)
      StDrain: begin
        hold_d = 1'b1;
        busy_d = 1'b1;
      end
      StSwitch, StSettle: begin
        hold_d     = 1'b1;
        busy_d     = 1'b1;
        daq_rate_d = target_d;
      end
      StRecover: begin
        hold_d     = 1'b1;
        busy_d     = 1'b1;
        fsm_rst_d  = 1'b1;
        daq_rate_d = RATE_1G25;
      end
      StError: err_d = 1'b1;
      StIdle:  done_d = (state_q == StSettle);
      default: ;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= StIdle;
      target_q       <= RATE_1G25;
      retry_q        <= '0;
      drain_forced_q <= 1'b0;
      daq_rate_q     <= RATE_1G25;
      fsm_rst_q      <= 1'b0;
      hold_q         <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      retry_q        <= retry_d;
      drain_forced_q <= drain_forced_d;
      daq_rate_q     <= daq_rate_d;
      fsm_rst_q      <= fsm_rst_d;
      hold_q         <= hold_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign DAQ_RATE     = daq_rate_q;
  assign RATE_FSM_RST = fsm_rst_q;
  assign HOLD_DATA    = hold_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign ERR          = err_q;
  assign DRAIN_FORCED = drain_forced_q;
  assign RETRY_CNT    = retry_q;
  assign SEQ_STATE    = state_q;

endmodule
